// File: rtl/spi_frame_master.sv
// rtl/spi_frame_master.sv - 16-bit SPI frame master for the bus-interface CPLD slave link
module spi_frame_master #(
  parameter int unsigned DIV = 4,
  parameter int unsigned GAP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  regnum,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        link_ok,
  output logic        sck,
  output logic        mosi,
  output logic        ss_n,
  input  logic        miso
);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_HIGH, S_LOW, S_TRAIL, S_GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] rdata_q, rdata_d;
  logic        link_ok_q, link_ok_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        ss_n_q, ss_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        div_last;

  assign div_last = (cnt_q == DIV_LAST);

  // State and every SPI/handshake output are registers, so sck and ss_n cannot glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rdata_q   <= '0;
      link_ok_q <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rdata_q   <= rdata_d;
      link_ok_q <= link_ok_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      ss_n_q    <= ss_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Frame sequencer: mosi moves on the edge that drops sck, miso is sampled on that same edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rdata_d   = rdata_q;
    link_ok_d = link_ok_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    ss_n_d    = ss_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          tx_d    = {5'b0, regnum, wdata};
          bit_d   = 4'd15;
          cnt_d   = '0;
          rdata_d = '0;
          ss_n_d  = 1'b0;
          mosi_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_LEAD;
        end
      end
      S_LEAD: begin
        if (div_last) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HIGH: begin
        if (div_last) begin
          cnt_d   = '0;
          sck_d   = 1'b0;
          rdata_d = {rdata_q[14:0], miso};
          if (bit_q != 4'd0) begin
            mosi_d = tx_q[bit_q - 4'd1];
          end
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_LOW: begin
        if (div_last) begin
          cnt_d = '0;
          if (bit_q == 4'd0) begin
            state_d = S_TRAIL;
          end else begin
            bit_d   = bit_q - 4'd1;
            sck_d   = 1'b1;
            state_d = S_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_TRAIL: begin
        if (div_last) begin
          cnt_d   = '0;
          ss_n_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d     = '0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          link_ok_d = (rdata_q[15:8] == 8'hEE);
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign link_ok = link_ok_q;
  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign ss_n    = ss_n_q;

endmodule
